// File: rtl/cpu_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_step_ctrl
// Purpose  : Front-panel run controller for the RCPU core. Conditions the
//            push button and switches, then sequences CPU reset, single-step
//            and free-run clock enables, and halts on CPU request.
// Revision : 1.0  initial release
// ============================================================================
module cpu_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int RST_HOLD        = 4,
    parameter int DIV1_LOG2       = 10,
    parameter int DIV2_LOG2       = 20,
    parameter int DIV3_LOG2       = 26
) (
    input  logic       clk_100MHz,
    input  logic       rst,
    input  logic       btn,
    input  logic [2:0] SW,
    input  logic       cpu_halt,
    output logic       cpu_ce,
    output logic       cpu_rst,
    output logic [2:0] ctrl_state,
    output logic [7:0] step_cnt
);

    localparam int c_DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int c_HOLD_W = $clog2(RST_HOLD + 1);
    localparam int c_DIV_W  = DIV3_LOG2;

    localparam logic [c_DB_W-1:0]   c_DB_MAX   = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(RST_HOLD - 1);
    localparam logic [c_DIV_W-1:0]  c_MASK1    = c_DIV_W'((64'd1 << DIV1_LOG2) - 64'd1);
    localparam logic [c_DIV_W-1:0]  c_MASK2    = c_DIV_W'((64'd1 << DIV2_LOG2) - 64'd1);
    localparam logic [c_DIV_W-1:0]  c_MASK3    = c_DIV_W'((64'd1 << DIV3_LOG2) - 64'd1);

    localparam logic [2:0] c_ST_RESET_HOLD = 3'd0;
    localparam logic [2:0] c_ST_IDLE       = 3'd1;
    localparam logic [2:0] c_ST_STEP       = 3'd2;
    localparam logic [2:0] c_ST_RUN        = 3'd3;
    localparam logic [2:0] c_ST_HALTED     = 3'd4;

    logic                r_btn_meta, r_btn_sync, r_btn_stable;
    logic [2:0]          r_sw_meta, r_sw_sync;
    logic [c_DB_W-1:0]   r_db_cnt;
    logic [2:0]          r_state;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic [c_DIV_W-1:0]  r_div;
    logic [1:0]          r_rate;
    logic                r_ce, r_cpu_rst;
    logic [7:0]          r_step_cnt;

    logic [c_DB_W-1:0]   w_db_cnt_nxt;
    logic                w_btn_stable_nxt, w_btn_press;
    logic [2:0]          w_state_nxt;
    logic [c_HOLD_W-1:0] w_hold_cnt_nxt;
    logic [c_DIV_W-1:0]  w_div_nxt, w_mask;
    logic                w_rate_chg, w_tick;
    logic                w_ce_nxt, w_cpu_rst_nxt;
    logic [7:0]          w_step_cnt_nxt;

    // Next-state logic: debounce, run-rate divider, control FSM and outputs.
    always_comb begin
        // Debounce: accept the synced level only after it differs from the
        // stable level for DEBOUNCE_CYCLES consecutive cycles.
        w_db_cnt_nxt     = r_db_cnt;
        w_btn_stable_nxt = r_btn_stable;
        if (r_btn_sync == r_btn_stable) begin
            w_db_cnt_nxt = '0;
        end else if (r_db_cnt == c_DB_MAX) begin
            w_btn_stable_nxt = r_btn_sync;
            w_db_cnt_nxt     = '0;
        end else begin
            w_db_cnt_nxt = r_db_cnt + 1'b1;
        end
        // Press is flagged in the cycle the stable level is about to rise so
        // the FSM acts on the same edge that updates the stable flop.
        w_btn_press = w_btn_stable_nxt & ~r_btn_stable;

        case (r_sw_sync[2:1])
            2'b00:   w_mask = '0;
            2'b01:   w_mask = c_MASK1;
            2'b10:   w_mask = c_MASK2;
            default: w_mask = c_MASK3;
        endcase
        // A rate change restarts the period; no tick in the change cycle.
        w_rate_chg = (r_sw_sync[2:1] != r_rate);
        w_tick     = (r_state == c_ST_RUN) && !w_rate_chg && (r_div == w_mask);

        w_state_nxt = r_state;
        case (r_state)
            c_ST_RESET_HOLD: begin
                if (r_hold_cnt == c_HOLD_MAX) begin
                    w_state_nxt = r_sw_sync[0] ? c_ST_RUN : c_ST_IDLE;
                end
            end
            c_ST_IDLE: begin
                if (cpu_halt)          w_state_nxt = c_ST_HALTED;
                else if (r_sw_sync[0]) w_state_nxt = c_ST_RUN;
                else if (w_btn_press)  w_state_nxt = c_ST_STEP;
            end
            c_ST_STEP: begin
                w_state_nxt = cpu_halt ? c_ST_HALTED : c_ST_IDLE;
            end
            c_ST_RUN: begin
                if (cpu_halt)           w_state_nxt = c_ST_HALTED;
                else if (!r_sw_sync[0]) w_state_nxt = c_ST_IDLE;
            end
            c_ST_HALTED: begin
                if (w_btn_press) w_state_nxt = c_ST_RESET_HOLD;
            end
            default: w_state_nxt = c_ST_RESET_HOLD;
        endcase

        // Divider only counts while running, so it is already zero on entry.
        if ((r_state != c_ST_RUN) || w_rate_chg || w_tick) begin
            w_div_nxt = '0;
        end else begin
            w_div_nxt = r_div + 1'b1;
        end

        w_hold_cnt_nxt = (r_state == c_ST_RESET_HOLD) ? r_hold_cnt + 1'b1 : '0;

        // Outputs are decoded from the next state so they register with it;
        // a tick leaving RUN (halt or mode change) is dropped.
        w_ce_nxt       = (w_state_nxt == c_ST_STEP) ||
                         (w_tick && (w_state_nxt == c_ST_RUN));
        w_cpu_rst_nxt  = (w_state_nxt == c_ST_RESET_HOLD);
        w_step_cnt_nxt = (w_state_nxt == c_ST_RESET_HOLD) ? 8'd0
                                                          : r_step_cnt + {7'd0, r_ce};
    end

    // State registers with synchronous reset; synchronisers included.
    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            r_btn_meta   <= 1'b0;
            r_btn_sync   <= 1'b0;
            r_sw_meta    <= 3'd0;
            r_sw_sync    <= 3'd0;
            r_btn_stable <= 1'b0;
            r_db_cnt     <= '0;
            r_state      <= c_ST_RESET_HOLD;
            r_hold_cnt   <= '0;
            r_div        <= '0;
            r_rate       <= 2'd0;
            r_ce         <= 1'b0;
            r_cpu_rst    <= 1'b1;
            r_step_cnt   <= 8'd0;
        end else begin
            r_btn_meta   <= btn;
            r_btn_sync   <= r_btn_meta;
            r_sw_meta    <= SW;
            r_sw_sync    <= r_sw_meta;
            r_btn_stable <= w_btn_stable_nxt;
            r_db_cnt     <= w_db_cnt_nxt;
            r_state      <= w_state_nxt;
            r_hold_cnt   <= w_hold_cnt_nxt;
            r_div        <= w_div_nxt;
            r_rate       <= r_sw_sync[2:1];
            r_ce         <= w_ce_nxt;
            r_cpu_rst    <= w_cpu_rst_nxt;
            r_step_cnt   <= w_step_cnt_nxt;
        end
    end

    assign cpu_ce     = r_ce;
    assign cpu_rst    = r_cpu_rst;
    assign ctrl_state = r_state;
    assign step_cnt   = r_step_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cpu_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_step_ctrl
// Purpose  : Self-checking bench for cpu_step_ctrl. Expected cpu_ce pulse
//            cycles are queued as stimulus is applied and matched by a monitor.
// Revision : 1.0  initial release
// ============================================================================
module tb_cpu_step_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic [2:0] SW  = 3'd0;
    logic       cpu_halt = 1'b0;
    logic       cpu_ce, cpu_rst;
    logic [2:0] ctrl_state;
    logic [7:0] step_cnt;

    int cyc = 0;
    int n_vec = 0;
    int n_fail = 0;
    int exp_steps = 0;
    int q_exp[$];

    cpu_step_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .RST_HOLD       (4),
        .DIV1_LOG2      (2),
        .DIV2_LOG2      (3),
        .DIV3_LOG2      (4)
    ) dut (
        .clk_100MHz(clk),
        .rst       (rst),
        .btn       (btn),
        .SW        (SW),
        .cpu_halt  (cpu_halt),
        .cpu_ce    (cpu_ce),
        .cpu_rst   (cpu_rst),
        .ctrl_state(ctrl_state),
        .step_cnt  (step_cnt)
    );

    always #5 clk = ~clk;

    // Cycle index: value N is visible from the Nth rising edge onward.
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every cpu_ce pulse must match the next queued cycle.
    always @(negedge clk) begin
        if (cpu_ce) begin
            n_vec++;
            if (q_exp.size() == 0) begin
                n_fail++;
                $display("FAIL ce_unexpected: pulse at cycle %0d, none expected", cyc);
            end else begin
                int e;
                e = q_exp.pop_front();
                if (e !== cyc) begin
                    n_fail++;
                    $display("FAIL ce_timing: pulse at cycle %0d, expected at cycle %0d", cyc, e);
                end
            end
        end
        if (cpu_ce && cpu_rst) begin
            n_vec++;
            n_fail++;
            $display("FAIL ce_rst_overlap: cpu_ce=1 cpu_rst=1 at cycle %0d, required not both", cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic push_range(input int first, input int last);
        for (int c = first; c <= last; c++) begin
            q_exp.push_back(c);
            exp_steps++;
        end
    endtask

    task automatic test_reset;
        SW  = 3'b000;
        rst = 1'b1;
        wait_cyc(1);
        n_vec++;
        if ({ctrl_state, cpu_rst, cpu_ce, step_cnt} !== {3'd0, 1'b1, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_values: st=%0d rst=%b ce=%b cnt=%0d, required st=0 rst=1 ce=0 cnt=0",
                     ctrl_state, cpu_rst, cpu_ce, step_cnt);
        end
        wait_cyc(2);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_cyc(2 + i);
            n_vec++;
            if ({ctrl_state, cpu_rst} !== {3'd0, 1'b1}) begin
                n_fail++;
                $display("FAIL reset_hold_%0d: st=%0d rst=%b, required st=0 rst=1", i, ctrl_state, cpu_rst);
            end
        end
        wait_cyc(6);
        n_vec++;
        if ({ctrl_state, cpu_rst, cpu_ce, step_cnt} !== {3'd1, 1'b0, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_to_idle: st=%0d rst=%b ce=%b cnt=%0d, required st=1 rst=0 ce=0 cnt=0",
                     ctrl_state, cpu_rst, cpu_ce, step_cnt);
        end
        exp_steps = 0;
    endtask

    task automatic test_step;
        // Bounce 1,0,0 then a clean edge at cycle 13 held for 10 cycles.
        wait_cyc(10); btn = 1'b1;
        wait_cyc(11); btn = 1'b0;
        wait_cyc(13); btn = 1'b1;
        push_range(13 + 6, 13 + 6);
        wait_cyc(23); btn = 1'b0;
        // One-cycle bounce on release.
        wait_cyc(25); btn = 1'b1;
        wait_cyc(26); btn = 1'b0;
        wait_cyc(40);
        n_vec++;
        if (q_exp.size() != 0) begin
            n_fail++;
            $display("FAIL step_missing: %0d pulses outstanding, required 0", q_exp.size());
        end
        n_vec++;
        if ({ctrl_state, step_cnt} !== {3'd1, 8'(exp_steps)}) begin
            n_fail++;
            $display("FAIL step_count: st=%0d cnt=%0d, required st=1 cnt=%0d", ctrl_state, step_cnt, exp_steps);
        end
    endtask

    task automatic test_run_rate;
        // Run at /4: entry at 43, ticks every 4 cycles, ce one cycle later.
        SW = 3'b011;
        for (int k = 0; k < 8; k++) push_range(40 + 7 + 4 * k, 40 + 7 + 4 * k);
        wait_cyc(76);
        n_vec++;
        if (q_exp.size() != 0) begin
            n_fail++;
            $display("FAIL run_div4: %0d pulses outstanding after 32 cycles, required 0", q_exp.size());
        end
        // Rate change to /1: divider clears two sync cycles later.
        SW = 3'b001;
        push_range(80, 89);
        wait_cyc(87);
        SW = 3'b000;
        wait_cyc(95);
        n_vec++;
        if (q_exp.size() != 0) begin
            n_fail++;
            $display("FAIL run_div1: %0d pulses outstanding, required 0", q_exp.size());
        end
        n_vec++;
        if ({ctrl_state, step_cnt} !== {3'd1, 8'(exp_steps)}) begin
            n_fail++;
            $display("FAIL run_exit: st=%0d cnt=%0d, required st=1 cnt=%0d", ctrl_state, step_cnt, exp_steps);
        end
    endtask

    task automatic test_halt_restart;
        SW = 3'b011;
        push_range(102, 102);
        push_range(106, 106);
        wait_cyc(109); cpu_halt = 1'b1;   // tick cycle: its ce must be dropped
        wait_cyc(110); cpu_halt = 1'b0;
        n_vec++;
        if (ctrl_state !== 3'd4) begin
            n_fail++;
            $display("FAIL halt_enter: st=%0d, required 4", ctrl_state);
        end
        wait_cyc(120);
        n_vec++;
        if ({ctrl_state, q_exp.size()} !== {3'd4, 32'd0}) begin
            n_fail++;
            $display("FAIL halt_stay: st=%0d pending=%0d, required st=4 pending=0", ctrl_state, q_exp.size());
        end
        btn = 1'b1;
        exp_steps = 0;
        push_range(134, 134);
        wait_cyc(126);
        n_vec++;
        if ({ctrl_state, cpu_rst, step_cnt} !== {3'd0, 1'b1, 8'd0}) begin
            n_fail++;
            $display("FAIL restart_enter: st=%0d rst=%b cnt=%0d, required st=0 rst=1 cnt=0",
                     ctrl_state, cpu_rst, step_cnt);
        end
        wait_cyc(129);
        n_vec++;
        if ({ctrl_state, cpu_rst} !== {3'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL restart_hold: st=%0d rst=%b, required st=0 rst=1", ctrl_state, cpu_rst);
        end
        wait_cyc(130);
        n_vec++;
        if ({ctrl_state, cpu_rst} !== {3'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL restart_run: st=%0d rst=%b, required st=3 rst=0", ctrl_state, cpu_rst);
        end
        wait_cyc(132); btn = 1'b0;
        wait_cyc(135);
        n_vec++;
        if (step_cnt !== 8'(exp_steps)) begin
            n_fail++;
            $display("FAIL restart_count: cnt=%0d, required %0d", step_cnt, exp_steps);
        end
    endtask

    task automatic test_wrap;
        cpu_halt = 1'b1;
        wait_cyc(136);
        cpu_halt = 1'b0;
        SW = 3'b001;
        n_vec++;
        if (ctrl_state !== 3'd4) begin
            n_fail++;
            $display("FAIL wrap_halt: st=%0d, required 4", ctrl_state);
        end
        wait_cyc(145);
        btn = 1'b1;
        exp_steps = 0;
        push_range(156, 411);
        wait_cyc(165); btn = 1'b0;
        wait_cyc(411);
        n_vec++;
        if (step_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL wrap_255: cnt=%0d, required 255", step_cnt);
        end
        cpu_halt = 1'b1;
        wait_cyc(412);
        cpu_halt = 1'b0;
        n_vec++;
        if ({ctrl_state, step_cnt, q_exp.size()} !== {3'd4, 8'(exp_steps), 32'd0}) begin
            n_fail++;
            $display("FAIL wrap_zero: st=%0d cnt=%0d pending=%0d, required st=4 cnt=%0d pending=0",
                     ctrl_state, step_cnt, q_exp.size(), exp_steps & 255);
        end
    endtask

    task automatic test_reset_abort;
        wait_cyc(420);
        btn = 1'b1;                 // hold entered at 426
        wait_cyc(427); rst = 1'b1;  // second hold cycle
        wait_cyc(428); rst = 1'b0;
        n_vec++;
        if ({ctrl_state, cpu_rst, cpu_ce, step_cnt} !== {3'd0, 1'b1, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL abort_hold: st=%0d rst=%b ce=%b cnt=%0d, required st=0 rst=1 ce=0 cnt=0",
                     ctrl_state, cpu_rst, cpu_ce, step_cnt);
        end
        wait_cyc(431);
        n_vec++;
        if ({ctrl_state, cpu_rst} !== {3'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL abort_hold_restart: st=%0d rst=%b, required st=0 rst=1", ctrl_state, cpu_rst);
        end
        exp_steps = 0;
        push_range(433, 437);
        wait_cyc(432);
        n_vec++;
        if (ctrl_state !== 3'd3) begin
            n_fail++;
            $display("FAIL abort_hold_run: st=%0d, required 3", ctrl_state);
        end
        wait_cyc(437);
        rst = 1'b1;
        SW  = 3'b000;
        btn = 1'b0;
        wait_cyc(438);
        rst = 1'b0;
        n_vec++;
        if ({ctrl_state, cpu_rst, cpu_ce, step_cnt} !== {3'd0, 1'b1, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL abort_run: st=%0d rst=%b ce=%b cnt=%0d, required st=0 rst=1 ce=0 cnt=0",
                     ctrl_state, cpu_rst, cpu_ce, step_cnt);
        end
        wait_cyc(442);
        n_vec++;
        if ({ctrl_state, cpu_rst, q_exp.size()} !== {3'd1, 1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL abort_recover: st=%0d rst=%b pending=%0d, required st=1 rst=0 pending=0",
                     ctrl_state, cpu_rst, q_exp.size());
        end
    endtask

    initial begin
        test_reset();
        test_step();
        test_run_rate();
        test_halt_restart();
        test_wrap();
        test_reset_abort();
        wait_cyc(450);
        n_vec++;
        if (q_exp.size() != 0) begin
            n_fail++;
            $display("FAIL final_queue: %0d pulses outstanding, required 0", q_exp.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_step_ctrl.md
Name: cpu_step_ctrl

Overview:
- Front-panel run controller for the RCPU core on the FPGA top.
- Debounces `btn`, synchronises `SW`, and issues the CPU clock-enable (`cpu_ce`) and CPU reset (`cpu_rst`).
- Supports single-step, free-run at four selectable rates, halt on CPU request, and restart.
- `step_cnt` goes to the LED mux for bring-up.

Parameters:
- DEBOUNCE_CYCLES, 1000000, cycles the synced btn must be stable before acceptance (10 ms at 100 MHz); must be >= 2.
- RST_HOLD, 4, cycles `cpu_rst` is held high on every (re)start; must be >= 1.
- DIV1_LOG2, 10, run rate for SW[2:1]=01 is one ce per 2^DIV1_LOG2 cycles.
- DIV2_LOG2, 20, run rate for SW[2:1]=10.
- DIV3_LOG2, 26, run rate for SW[2:1]=11; sets the divider width.

Ports:
- clk_100MHz  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- btn  in  1  raw push button, asynchronous and bouncy.
- SW  in  3  raw switches. SW[0]: 0=step mode, 1=run mode. SW[2:1]: run rate select.
- cpu_halt  in  1  CPU halt request, synchronous to clk_100MHz.
- cpu_ce  out  1  CPU clock enable, single-cycle pulses.
- cpu_rst  out  1  CPU synchronous reset.
- ctrl_state  out  3  FSM state code.
- step_cnt  out  8  count of cpu_ce pulses since the last restart.

Behaviour:
- Reset is synchronous and active-high; the clock is clk_100MHz. While rst=1 on a clock edge:
  - state=RESET_HOLD, hold counter=0.
  - cpu_rst=1, cpu_ce=0, step_cnt=0, ctrl_state=3'd0.
  - Sync and debounce registers cleared; the debounced button is 0.
- Input conditioning:
  - btn and SW each pass through a 2-FF synchroniser.
  - Debounce counter resets whenever synced btn equals the stable value; otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, stable takes the synced value and the counter clears.
  - btn_press is a 1-cycle pulse on a 0->1 change of stable.
  - Press latency from a clean btn edge: 2 + DEBOUNCE_CYCLES cycles. Release bounces never produce a press.
- FSM states and codes: RESET_HOLD=0, IDLE=1, STEP=2, RUN=3, HALTED=4. cpu_ce and cpu_rst are registered Moore outputs.
- RESET_HOLD:
  - cpu_rst=1 and the hold counter increments.
  - After RST_HOLD cycles in this state, go to RUN if SW_sync[0]=1, else IDLE.
  - step_cnt is cleared on entry.
- IDLE (checked in this order):
  - cpu_halt=1 -> HALTED.
  - else SW_sync[0]=1 -> RUN.
  - else btn_press -> STEP.
- STEP:
  - cpu_ce=1 for exactly one cycle, then IDLE.
  - cpu_halt=1 in this cycle -> HALTED, but the ce pulse has already been issued.
- RUN:
  - Divider is cleared on entry. tick when divider == period-1, then the divider wraps to 0.
  - Period by SW_sync[2:1]: 00=1 (tick every cycle), 01=2^DIV1_LOG2, 10=2^DIV2_LOG2, 11=2^DIV3_LOG2.
  - A rate change mid-run clears the divider.
  - cpu_ce = tick registered, i.e. ce is asserted the cycle after tick.
  - cpu_halt=1 -> HALTED; a pending ce is suppressed.
  - SW_sync[0]=0 -> IDLE, with the same suppression.
  - Priority: halt > mode change. btn is ignored in RUN.
- HALTED:
  - cpu_ce=0.
  - btn_press -> RESET_HOLD (restart the CPU). Nothing else exits this state.
- step_cnt increments on every cycle with cpu_ce=1 and wraps 255->0.
- rst asserted mid-operation (any state, mid-debounce, mid-hold) aborts immediately to the reset values above. No ce pulse is emitted in that cycle.
- cpu_ce and cpu_rst are never both 1.

Test Plan (DEBOUNCE_CYCLES=4, RST_HOLD=4, DIV1_LOG2=2, DIV2_LOG2=3, DIV3_LOG2=4):
1. Reset, SW=000 -> cpu_rst=1 for 4 cycles after release, then ctrl_state=1, cpu_ce=0, step_cnt=0.
2. Step mode, btn with 3 cycles of bouncing then held high for 10 cycles -> exactly one cpu_ce pulse 6 cycles after the clean edge; step_cnt=1. A bounce on release produces no extra pulse.
3. SW=011 (run, /4) -> cpu_ce pulses every 4 cycles, 8 pulses in 32 cycles. Switch to SW=001 -> pulses every cycle after 2 sync cycles plus divider clear.
4. RUN with cpu_halt=1 for 1 cycle -> ctrl_state=4, no further cpu_ce. A btn press -> RESET_HOLD, cpu_rst high for 4 cycles, step_cnt=0, then RUN.
5. Run 256 ce pulses at SW=001 -> step_cnt wraps to 0.
6. rst asserted during RESET_HOLD cycle 2 and during a RUN tick cycle -> outputs take reset values on that edge, no cpu_ce pulse, and the hold restarts from 0.
